// File: rtl/slc3_pkg.sv
// Shared SLC-3 definitions: PC source encoding and the default reset PC.
package slc3_pkg;

  typedef enum logic [1:0] {
    PC_INC   = 2'b00,
    PC_BUS   = 2'b01,
    PC_OFF9  = 2'b10,
    PC_OFF11 = 2'b11
  } pcmux_t;

  localparam logic [15:0] SLC3_RESET_PC = 16'h0000;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/pc_offset_adder.sv
// Sign-extends an OffW-bit instruction offset and adds it to the PC, modulo 2^16.
module pc_offset_adder #(
  parameter int unsigned OffW = 9
) (
  input  logic [15:0]     pc_i,
  input  logic [OffW-1:0] offset_i,
  output logic [15:0]     target_o
);

  logic [15:0] offset_sext;

  assign offset_sext = {{(16 - OffW){offset_i[OffW-1]}}, offset_i};
  assign target_o    = pc_i + offset_sext;

endmodule

// File: rtl/branch_pc_unit.sv
// SLC-3 program counter and branch-enable register.
// Branch statistics counters are built only when SLC3_BR_STATS_EN is defined.
module branch_pc_unit
  import slc3_pkg::*;
#(
  parameter logic [15:0] RESET_PC = SLC3_RESET_PC
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        ben_in,
  input  logic        ld_ben,
  input  logic        ld_pc,
  input  logic [1:0]  pcmux_sel,
  input  logic [15:0] bus,
  input  logic [15:0] ir,
  output logic [15:0] pc,
  output logic        ben,
  output logic [15:0] br_total,
  output logic [15:0] br_taken
);

  logic [15:0] pc_q, pc_d;
  logic        ben_q, ben_d;
  logic [15:0] target_off9, target_off11;
  pcmux_t      pcmux;

  // Opcode bits feed the control FSM, not this unit.
  logic unused_ir;
  assign unused_ir = ^ir[15:11];

  assign pcmux = pcmux_t'(pcmux_sel);

  pc_offset_adder #(
    .OffW (9)
  ) u_off9 (
    .pc_i     (pc_q),
    .offset_i (ir[8:0]),
    .target_o (target_off9)
  );

  pc_offset_adder #(
    .OffW (11)
  ) u_off11 (
    .pc_i     (pc_q),
    .offset_i (ir[10:0]),
    .target_o (target_off11)
  );

  always_comb begin
    pc_d = pc_q;
    if (ld_pc) begin
      unique case (pcmux)
        PC_INC:   pc_d = pc_q + 16'd1;
        PC_BUS:   pc_d = bus;
        PC_OFF9:  pc_d = target_off9;
        PC_OFF11: pc_d = target_off11;
        default:  pc_d = pc_q;
      endcase
    end
  end

  always_comb begin
    ben_d = ben_q;
    if (ld_ben) begin
      ben_d = ben_in;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      pc_q  <= RESET_PC;
      ben_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ben_q <= ben_d;
    end
  end

  assign pc  = pc_q;
  assign ben = ben_q;

`ifdef SLC3_BR_STATS_EN
  logic [15:0] total_q, total_d;
  logic [15:0] taken_q, taken_d;

  always_comb begin
    total_d = total_q;
    taken_d = taken_q;
    if (ld_ben) begin
      total_d = sat_inc16(total_q);
      if (ben_in) begin
        taken_d = sat_inc16(taken_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      total_q <= 16'h0000;
      taken_q <= 16'h0000;
    end else begin
      total_q <= total_d;
      taken_q <= taken_d;
    end
  end

  assign br_total = total_q;
  assign br_taken = taken_q;
`else
  assign br_total = 16'h0000;
  assign br_taken = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench for branch_pc_unit: a driver pushes model predictions, a monitor
// pops one per clock and compares against the registered outputs.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        ben_in = 1'b0;
  logic        ld_ben = 1'b0;
  logic        ld_pc = 1'b0;
  logic [1:0]  pcmux_sel = 2'b00;
  logic [15:0] bus = 16'h0000;
  logic [15:0] ir = 16'h0000;
  logic [15:0] pc;
  logic        ben;
  logic [15:0] br_total;
  logic [15:0] br_taken;

  branch_pc_unit #(
    .RESET_PC (16'h0000)
  ) dut (
    .clk       (clk),
    .Reset     (Reset),
    .ben_in    (ben_in),
    .ld_ben    (ld_ben),
    .ld_pc     (ld_pc),
    .pcmux_sel (pcmux_sel),
    .bus       (bus),
    .ir        (ir),
    .pc        (pc),
    .ben       (ben),
    .br_total  (br_total),
    .br_taken  (br_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] pc;
    logic        ben;
    logic [15:0] total;
    logic [15:0] taken;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference state, kept as plain integers.
  int m_pc = 0;
  int m_ben = 0;
  int m_total = 0;
  int m_taken = 0;

  function automatic int sext(input int val, input int bits);
    return (val >= (1 << (bits - 1))) ? val - (1 << bits) : val;
  endfunction

  function automatic int wrap16(input int val);
    return ((val % 65536) + 65536) % 65536;
  endfunction

  // One clock of stimulus: drive on the falling edge, predict the state after the next rise.
  task automatic step(input string tag, input bit rst, input bit lpc, input int sel,
                      input int bus_v, input int ir_v, input bit lben, input bit bin);
    exp_t e;
    @(negedge clk);
    Reset     = rst;
    ld_pc     = lpc;
    pcmux_sel = 2'(sel);
    bus       = 16'(bus_v);
    ir        = 16'(ir_v);
    ld_ben    = lben;
    ben_in    = bin;
    if (rst) begin
      m_pc = 0; m_ben = 0; m_total = 0; m_taken = 0;
    end else begin
      if (lpc) begin
        case (sel)
          0: m_pc = wrap16(m_pc + 1);
          1: m_pc = bus_v & 16'hFFFF;
          2: m_pc = wrap16(m_pc + sext(ir_v % 512, 9));
          default: m_pc = wrap16(m_pc + sext(ir_v % 2048, 11));
        endcase
      end
      if (lben) m_ben = bin;
`ifdef SLC3_BR_STATS_EN
      if (lben && m_total < 65535) m_total++;
      if (lben && bin && m_taken < 65535) m_taken++;
`endif
    end
    e.tag = tag; e.pc = 16'(m_pc); e.ben = 1'(m_ben);
    e.total = 16'(m_total); e.taken = 16'(m_taken);
    exp_q.push_back(e);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are registered, so every clock presents one new result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (pc !== e.pc) begin
          failures++;
          $display("FAIL %s pc: got %h expected %h", e.tag, pc, e.pc);
        end
        checks++;
        if (ben !== e.ben) begin
          failures++;
          $display("FAIL %s ben: got %b expected %b", e.tag, ben, e.ben);
        end
        checks++;
        if (br_total !== e.total) begin
          failures++;
          $display("FAIL %s br_total: got %h expected %h", e.tag, br_total, e.total);
        end
        checks++;
        if (br_taken !== e.taken) begin
          failures++;
          $display("FAIL %s br_taken: got %h expected %h", e.tag, br_taken, e.taken);
        end
      end
    end
  end

  initial begin
    int wait_cycles;
    step("reset", 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    idle("after_reset");

    step("load_ffff", 1'b0, 1'b1, 1, 16'hFFFF, 0, 1'b0, 1'b0);
    step("inc_wrap", 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0);
    idle("hold_pc");

    step("load_3001", 1'b0, 1'b1, 1, 16'h3001, 0, 1'b0, 1'b0);
    step("off9_neg2", 1'b0, 1'b1, 2, 0, 16'h01FE, 1'b0, 1'b0);
    step("off11_pos5", 1'b0, 1'b1, 3, 0, 16'h0005, 1'b0, 1'b0);

    step("bus_and_ben", 1'b0, 1'b1, 1, 16'hABCD, 0, 1'b1, 1'b1);
    idle("hold_ben");

    step("br_1", 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b1);
    step("br_0", 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
    step("br_1b", 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b1);

    step("reset_vs_load", 1'b1, 1'b1, 1, 16'h1234, 0, 1'b1, 1'b1);
    idle("after_reset2");

    for (int i = 0; i < 400; i++) begin
      step("random", ($urandom_range(0, 31) == 0), 1'($urandom), $urandom_range(0, 3),
           int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
           1'($urandom), 1'($urandom));
    end

`ifdef SLC3_BR_STATS_EN
    step("sat_reset", 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 65537; i++) begin
      step("saturate", 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b1);
    end
`endif

    idle("drain");
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
